// File: rtl/sram_1rw_64x64_req_ctrl_if.sv
// Request/response bundle between the requester, the controller and the SRAM pins.
interface sram_1rw_64x64_req_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              sram_en;
    logic              sram_write;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_write_data;
    logic [DATA_W-1:0] sram_read_data;

    // Environment side: issues requests, consumes responses, models the SRAM.
    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, resp_ready, sram_read_data,
        input  wr_ready, rd_ready, resp_valid, resp_data,
        input  sram_en, sram_write, sram_addr, sram_write_data
    );

    // Controller side.
    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, resp_ready, sram_read_data,
        output wr_ready, rd_ready, resp_valid, resp_data,
        output sram_en, sram_write, sram_addr, sram_write_data
    );
endinterface

// File: rtl/sram_1rw_64x64_req_ctrl.sv
// Read/write arbiter in front of the 64x64 single-port SRAM, with a
// credit-limited response FIFO capturing the 1-cycle-latency read data.
module sram_1rw_64x64_req_ctrl #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 64,
    parameter int RESP_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    sram_1rw_64x64_req_ctrl_if.slave    bus
);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W = $clog2(RESP_DEPTH);

    typedef enum logic {
        PRI_WR = 1'b0,
        PRI_RD = 1'b1
    } pri_e;

    pri_e              pri_q, pri_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [DATA_W-1:0] mem_q [RESP_DEPTH];

    logic              grant_wr, grant_rd;
    logic              wr_elig, rd_elig, rd_ok;
    logic              push, pop;
    logic [CNT_W:0]    occ;

    assign push = inflight_q;
    assign pop  = (count_q != '0) && bus.resp_ready;

    // Occupancy counts the in-flight read too, so every issued read already owns a slot.
    assign occ   = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign rd_ok = occ < (CNT_W+1)'(RESP_DEPTH);

    // Gating with rst_n keeps the SRAM idle during reset, independent of the inputs.
    assign wr_elig = rst_n && bus.wr_valid;
    assign rd_elig = rst_n && bus.rd_valid && rd_ok;

    // Round-robin grant; the pointer always moves to the side that was not served.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        pri_d    = pri_q;
        if (wr_elig && rd_elig) begin
            if (pri_q == PRI_WR) grant_wr = 1'b1;
            else                 grant_rd = 1'b1;
        end else if (wr_elig) begin
            grant_wr = 1'b1;
        end else if (rd_elig) begin
            grant_rd = 1'b1;
        end
        if (grant_wr)      pri_d = PRI_RD;
        else if (grant_rd) pri_d = PRI_WR;
    end

    assign bus.wr_ready        = grant_wr;
    assign bus.rd_ready        = grant_rd;
    assign bus.sram_en         = grant_wr | grant_rd;
    assign bus.sram_write      = grant_wr;
    assign bus.sram_addr       = grant_rd ? bus.rd_addr : bus.wr_addr;
    assign bus.sram_write_data = bus.wr_data;

    assign bus.resp_valid = (count_q != '0);
    assign bus.resp_data  = mem_q[rptr_q];

    // Next-state for FIFO pointers, occupancy and the read-in-flight flag.
    always_comb begin
        inflight_d = grant_rd;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        if (push) wptr_d = (wptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        if (pop)  rptr_d = (rptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset drops queued and in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_q      <= PRI_WR;
            count_q    <= '0;
            inflight_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            pri_q      <= pri_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Response storage: capture SRAM read data the cycle after the read access.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= bus.sram_read_data;
    end
endmodule

// File: tb/tb_sram_1rw_64x64_req_ctrl.sv
// Directed bench for the SRAM request controller with a behavioural SRAM.
module tb_sram_1rw_64x64_req_ctrl;
    localparam int RESP_DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] sram_mem [64];

    sram_1rw_64x64_req_ctrl_if #(.ADDR_W(6), .DATA_W(64)) bus ();

    sram_1rw_64x64_req_ctrl #(.ADDR_W(6), .DATA_W(64), .RESP_DEPTH(RESP_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM, 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_write) sram_mem[bus.sram_addr] = bus.sram_write_data;
            else                bus.sram_read_data <= sram_mem[bus.sram_addr];
        end
    end

    // A push into a full FIFO must never happen.
    always @(posedge clk) begin
        if (rst_n && dut.inflight_q) begin
            checks++;
            if ((dut.count_q == RESP_DEPTH) && !(bus.resp_valid && bus.resp_ready)) begin
                errors++;
                $display("FAIL fifo_overflow push into full FIFO at %0t", $time);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wv, input logic [5:0] wa, input logic [63:0] wd,
                         input logic rv, input logic [5:0] ra, input logic rr);
        bus.wr_valid   = wv;
        bus.wr_addr    = wa;
        bus.wr_data    = wd;
        bus.rd_valid   = rv;
        bus.rd_addr    = ra;
        bus.resp_ready = rr;
    endtask

    // SRAM contents as seen by reads: preload = address, addr 5 rewritten by the first test.
    function automatic logic [63:0] expv(input int a);
        return (a == 5) ? 64'hDEADBEEF_00000005 : 64'(a);
    endfunction

    typedef struct {
        logic        wv;
        logic [5:0]  wa;
        logic [63:0] wd;
        logic        rv;
        logic [5:0]  ra;
        logic        rr;
        logic        ewr;
        logic        erd;
        logic        een;
        logic        ewe;
        logic [5:0]  eaddr;
        logic        erv;
        logic [63:0] edata;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int issued;
        int got;
        int cyc;

        for (int i = 0; i < 64; i++) sram_mem[i] = 64'(i);
        bus.sram_read_data = '0;

        // Write-then-read of addr 5, then 6 cycles of contested W/R traffic.
        vecs[0]  = '{1'b1, 6'd5,  64'hDEADBEEF_00000005, 1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd5,  1'b0, 64'h0};
        vecs[1]  = '{1'b0, 6'd0,  64'h0,                 1'b1, 6'd5,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd5,  1'b0, 64'h0};
        vecs[2]  = '{1'b0, 6'd0,  64'h0,                 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 64'h0};
        vecs[3]  = '{1'b0, 6'd0,  64'h0,                 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 64'hDEADBEEF_00000005};
        vecs[4]  = '{1'b0, 6'd0,  64'h0,                 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 64'h0};
        vecs[5]  = '{1'b1, 6'd40, 64'hA0A0_0000_0000_0040, 1'b1, 6'd20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd40, 1'b0, 64'h0};
        vecs[6]  = '{1'b1, 6'd41, 64'hA1A1_0000_0000_0041, 1'b1, 6'd20, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd20, 1'b0, 64'h0};
        vecs[7]  = '{1'b1, 6'd41, 64'hA1A1_0000_0000_0041, 1'b1, 6'd21, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd41, 1'b0, 64'h0};
        vecs[8]  = '{1'b1, 6'd42, 64'hA2A2_0000_0000_0042, 1'b1, 6'd21, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd21, 1'b1, 64'd20};
        vecs[9]  = '{1'b1, 6'd42, 64'hA2A2_0000_0000_0042, 1'b1, 6'd22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd42, 1'b0, 64'h0};
        vecs[10] = '{1'b1, 6'd43, 64'hA3A3_0000_0000_0043, 1'b1, 6'd22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd22, 1'b1, 64'd21};
        vecs[11] = '{1'b0, 6'd0,  64'h0,                 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 64'h0};
        vecs[12] = '{1'b0, 6'd0,  64'h0,                 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 64'd22};
        vecs[13] = '{1'b0, 6'd0,  64'h0,                 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 64'h0};

        // Reset: SRAM must stay idle even with both requests valid.
        rst_n = 1'b0;
        drive(1'b1, 6'd1, 64'h1, 1'b1, 6'd2, 1'b1);
        #2;
        chk("rst_sram_en",    64'(bus.sram_en),    64'd0);
        chk("rst_sram_write", 64'(bus.sram_write), 64'd0);
        chk("rst_wr_ready",   64'(bus.wr_ready),   64'd0);
        chk("rst_rd_ready",   64'(bus.rd_ready),   64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 1'b1);
        #2;
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].ra, vecs[i].rr);
            #2;
            chk($sformatf("v%0d_wr_ready", i),   64'(bus.wr_ready),   64'(vecs[i].ewr));
            chk($sformatf("v%0d_rd_ready", i),   64'(bus.rd_ready),   64'(vecs[i].erd));
            chk($sformatf("v%0d_sram_en", i),    64'(bus.sram_en),    64'(vecs[i].een));
            chk($sformatf("v%0d_sram_write", i), 64'(bus.sram_write), 64'(vecs[i].ewe));
            if (vecs[i].een) chk($sformatf("v%0d_sram_addr", i), 64'(bus.sram_addr), 64'(vecs[i].eaddr));
            if (vecs[i].ewe) chk($sformatf("v%0d_sram_wdata", i), bus.sram_write_data, vecs[i].wd);
            chk($sformatf("v%0d_resp_valid", i), 64'(bus.resp_valid), 64'(vecs[i].erv));
            if (vecs[i].erv) chk($sformatf("v%0d_resp_data", i), bus.resp_data, vecs[i].edata);
        end

        // Back-pressure: only RESP_DEPTH reads accepted while resp_ready=0.
        issued = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(1'b0, 6'd0, 64'h0, 1'b1, issued[5:0], 1'b0);
            #2;
            chk($sformatf("bp_rd_ready_c%0d", c), 64'(bus.rd_ready), (c < 2) ? 64'd1 : 64'd0);
            if (bus.rd_ready) issued++;
        end
        chk("bp_accepted", 64'(issued), 64'd2);
        got = 0;
        cyc = 0;
        while (cyc < 40 && got < 8) begin
            @(negedge clk);
            drive(1'b0, 6'd0, 64'h0, issued < 8, (issued < 8) ? issued[5:0] : 6'd0, 1'b1);
            #2;
            if (bus.resp_valid) begin
                chk($sformatf("bp_resp_data_%0d", got), bus.resp_data, expv(got));
                got++;
            end
            if (bus.rd_ready) issued++;
            cyc++;
        end
        chk("bp_resp_count", 64'(got), 64'd8);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 1'b1);
            #2;
            chk("bp_no_dup", 64'(bus.resp_valid), 64'd0);
        end

        // Streaming reads, one per cycle, responses two cycles later.
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            drive(1'b0, 6'd0, 64'h0, c < 16, 6'(c), 1'b1);
            #2;
            chk($sformatf("st_rd_ready_c%0d", c),   64'(bus.rd_ready),   (c < 16) ? 64'd1 : 64'd0);
            chk($sformatf("st_resp_valid_c%0d", c), 64'(bus.resp_valid), (c >= 2) ? 64'd1 : 64'd0);
            if (c >= 2) chk($sformatf("st_resp_data_c%0d", c), bus.resp_data, expv(c - 2));
        end
        @(negedge clk);
        drive(1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 1'b1);
        #2;
        chk("st_idle_resp_valid", 64'(bus.resp_valid), 64'd0);

        // Full FIFO: writes still flow, reads stay blocked.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(1'b0, 6'd0, 64'h0, 1'b1, 6'(c), 1'b0);
            #2;
            chk("fw_fill_rd_ready", 64'(bus.rd_ready), 64'd1);
        end
        @(negedge clk);
        drive(1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, 6'(48 + c), 64'hF0F0_0000_0000_0000 | 64'(c), 1'b1, 6'd2, 1'b0);
            #2;
            chk("fw_wr_ready",   64'(bus.wr_ready),   64'd1);
            chk("fw_rd_ready",   64'(bus.rd_ready),   64'd0);
            chk("fw_sram_write", 64'(bus.sram_write), 64'd1);
            chk("fw_resp_valid", 64'(bus.resp_valid), 64'd1);
        end
        got = 0;
        cyc = 0;
        while (cyc < 6 && got < 2) begin
            @(negedge clk);
            drive(1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 1'b1);
            #2;
            if (bus.resp_valid) begin
                chk($sformatf("fw_resp_data_%0d", got), bus.resp_data, expv(got));
                got++;
            end
            cyc++;
        end
        chk("fw_resp_count", 64'(got), 64'd2);

        // Asynchronous reset with one read in flight and one response queued.
        @(negedge clk);
        drive(1'b0, 6'd0, 64'h0, 1'b1, 6'd2, 1'b0);
        #2;
        chk("ar_rd0_ready", 64'(bus.rd_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 6'd0, 64'h0, 1'b1, 6'd3, 1'b0);
        #2;
        chk("ar_rd1_ready", 64'(bus.rd_ready), 64'd1);
        @(negedge clk);
        drive(1'b1, 6'd52, 64'h5252, 1'b1, 6'd6, 1'b0);
        #2;
        chk("ar_pre_resp_valid", 64'(bus.resp_valid), 64'd1);
        chk("ar_pre_rd_ready",   64'(bus.rd_ready),   64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("ar_sram_en",    64'(bus.sram_en),    64'd0);
        chk("ar_wr_ready",   64'(bus.wr_ready),   64'd0);
        @(negedge clk);
        chk("ar_hold_resp_valid", 64'(bus.resp_valid), 64'd0);
        rst_n = 1'b1;
        drive(1'b1, 6'd52, 64'h5252, 1'b1, 6'd4, 1'b1);
        #2;
        chk("ar_first_wr_ready", 64'(bus.wr_ready),   64'd1);
        chk("ar_first_rd_ready", 64'(bus.rd_ready),   64'd0);
        chk("ar_first_resp",     64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        drive(1'b0, 6'd0, 64'h0, 1'b1, 6'd4, 1'b1);
        #2;
        chk("ar_rd_ready",  64'(bus.rd_ready),   64'd1);
        chk("ar_no_stale0", 64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        drive(1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 1'b1);
        #2;
        chk("ar_no_stale1", 64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        #2;
        chk("ar_resp_valid_new", 64'(bus.resp_valid), 64'd1);
        chk("ar_resp_data_new",  bus.resp_data,       expv(4));
        @(negedge clk);
        #2;
        chk("ar_resp_drained", 64'(bus.resp_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_1rw_64x64_req_ctrl.md
Name: sram_1rw_64x64_req_ctrl

Overview:
Request front-end that sits directly upstream of the 64x64 single-port SRAM wrapper and drives its en/write/addr/write_data pins. It arbitrates independent read and write valid/ready request channels onto the one SRAM port, one access per cycle. It captures the SRAM's 1-cycle-latency read data into a small response FIFO with a valid/ready output. Read issue is credit-limited, so no read data is ever dropped under back-pressure.

Parameters:
ADDR_W, 6, SRAM address width (64 entries)
DATA_W, 64, SRAM data width
RESP_DEPTH, 2, response FIFO entries; legal values >= 2

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
wr_valid  in  1  write request valid
wr_ready  out  1  write request accepted this cycle
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_valid  in  1  read request valid
rd_ready  out  1  read request accepted this cycle
rd_addr  in  ADDR_W  read address
resp_valid  out  1  read response available
resp_ready  in  1  consumer takes response
resp_data  out  DATA_W  read response data, in request order
sram_en  out  1  to SRAM en
sram_write  out  1  to SRAM write
sram_addr  out  ADDR_W  to SRAM addr
sram_write_data  out  DATA_W  to SRAM write_data
sram_read_data  in  DATA_W  from SRAM read_data, valid the cycle after a read access

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state:
  - resp_valid=0, FIFO count=0, in-flight flag=0, priority pointer=WRITE.
  - sram_en=0 and sram_write=0 are guaranteed while rst_n=0.
  - resp_data is don't-care while resp_valid=0.
- Read credit:
  - rd_ok = (count + inflight - (resp_valid & resp_ready)) < RESP_DEPTH.
  - inflight = 1 in the cycle after a read was issued to the SRAM.
- Arbitration (combinational, same cycle):
  - Only wr_valid: grant write.
  - Only rd_valid & rd_ok: grant read.
  - Both eligible: grant the side named by the priority pointer. The pointer then flips to the other side, giving round-robin alternation.
  - A lone grant sets the pointer to the non-granted side.
  - rd_valid with !rd_ok is not eligible, and the write proceeds if present.
- Grant outputs:
  - wr_ready = write granted; rd_ready = read granted. At most one is 1 per cycle.
  - Ready is never asserted without the matching valid.
- SRAM drive (combinational from the grant, same cycle as the accepting handshake):
  - Write grant: sram_en=1, sram_write=1, sram_addr=wr_addr, sram_write_data=wr_data.
  - Read grant: sram_en=1, sram_write=0, sram_addr=rd_addr. sram_write_data holds wr_data as don't-care.
  - No grant: sram_en=0, sram_write=0.
- Read pipeline:
  - Read accepted in cycle N → inflight=1 in cycle N+1.
  - sram_read_data is written into the FIFO at the end of N+1.
  - resp_valid is high from cycle N+2 until popped.
  - Minimum request-to-response latency: 2 cycles.
- FIFO:
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pop occurs when resp_valid & resp_ready.
  - Ordering is strict FIFO, and the read pointer wraps modulo RESP_DEPTH.
  - A push into a full FIFO cannot occur by construction of the credit rule; the bench asserts this.
- Ordering: accesses reach the SRAM in grant order. A read granted the cycle after a write to the same address returns the new data; the SRAM provides this naturally.
- Throughput: with resp_ready held at 1, back-to-back reads sustain 1 per cycle at RESP_DEPTH=2.
- Reset mid-operation: asserting rst_n drops any in-flight read and all FIFO contents immediately. No response is produced for reads accepted before reset.

Test Plan:
- Write 0xDEADBEEF_00000005 to addr 5, then read addr 5 next cycle, resp_ready=1 → wr_ready cycle0, rd_ready cycle1, resp_valid cycle3 with resp_data=0xDEADBEEF_00000005; sram_en=1 on cycles 0 and 1 only.
- wr_valid and rd_valid held at 1 for 6 cycles, resp_ready=1, all addrs distinct → grants alternate W,R,W,R,W,R; 3 responses in issue order.
- rd_valid=1 for addrs 0..7 (preloaded with value = addr), resp_ready=0 → exactly 2 reads accepted, rd_ready then 0. Raise resp_ready → responses 0..7 in order, no loss, no duplicates.
- Streaming reads addrs 0..15 with resp_ready=1 → rd_ready high every cycle; resp_valid continuous from cycle 2 to 17.
- Back-pressure blocks reads while writes pending: FIFO full, wr_valid=1 → write still granted each cycle and rd_ready=0.
- rst_n pulsed low asynchronously mid-cycle while 1 read is in flight and 1 response is queued → resp_valid=0 and sram_en=0 immediately. After release, first grant uses WRITE priority and no stale response appears.
